// File: rtl/rr_arb_mux_pkg.sv
// Shared definitions for the round-robin / fixed-priority packet arbiter mux:
// lock-FSM state encodings, arbitration mode names and a select-width helper.
package rr_arb_mux_pkg;

    localparam logic [0:0] ARB_IDLE = 1'b0;
    localparam logic [0:0] ARB_LOCK = 1'b1;

    localparam string MODE_RR    = "RR";
    localparam string MODE_FIXED = "FIXED";

    // Width of a binary lane index; a single lane still needs one bit.
    function automatic int arb_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arb_mux_pick.sv
// Rotating-priority one-hot picker: the first req at or above the one-hot ptr,
// wrapping to index 0, found with a double-width masked lowest-set-bit search.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic         any
);

    localparam logic [2*N-1:0] ONE = 1;

    logic [2*N-1:0] dreq;
    logic [2*N-1:0] mask;
    logic [2*N-1:0] masked;
    logic [2*N-1:0] first;

    // Lower copy keeps only lanes >= ptr; upper copy supplies the wrapped lanes.
    assign dreq   = {req, req};
    assign mask   = ~({{N{1'b0}}, ptr} - ONE);
    assign masked = dreq & mask;
    assign first  = masked & (~masked + ONE);
    assign gnt    = first[N-1:0] | first[2*N-1:N];
    assign any    = |req;

endmodule

// File: rtl/rr_arb_mux.sv
// N-lane packet arbiter with rotating or fixed priority, per-packet lock,
// valid/ready flow control and a registered single-beat output stage.
module rr_arb_mux
    import rr_arb_mux_pkg::*;
#(
    parameter int    N     = 4,
    parameter int    WIDTH = 16,
    parameter string MODE  = MODE_RR,
    parameter int    SW    = arb_clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_valid,
    input  logic [N*WIDTH-1:0] req_data,
    input  logic [N-1:0]     req_last,
    output logic [N-1:0]     req_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [SW-1:0]    out_src,
    output logic             out_last,
    input  logic             out_ready
);

    localparam bit IS_FIXED = (MODE == MODE_FIXED);

    logic [0:0]       state_reg;
    logic [N-1:0]     ptr_reg;
    logic [SW-1:0]    owner_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic [SW-1:0]    out_src_reg;
    logic             out_last_reg;

    logic             load;
    logic             accept;
    logic             pick_any;
    logic             sel_last;
    logic [N-1:0]     pick_ptr;
    logic [N-1:0]     pick_gnt;
    logic [N-1:0]     owner_oh;
    logic [N-1:0]     grant;
    logic [N-1:0]     ptr_next;
    logic [WIDTH-1:0] sel_data;
    logic [SW-1:0]    win_idx;
    logic [WIDTH-1:0] lane_data [N];

    assign load     = ~out_valid_reg | out_ready;
    assign pick_ptr = IS_FIXED ? N'(1) : ptr_reg;

    rr_pick #(.N(N)) u_pick (
        .req (req_valid),
        .ptr (pick_ptr),
        .gnt (pick_gnt),
        .any (pick_any)
    );

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            assign owner_oh[gi]  = (owner_reg == SW'(gi));
            assign lane_data[gi] = {WIDTH{grant[gi]}} & req_data[gi*WIDTH +: WIDTH];
        end

        // A single lane has nothing to arbitrate, so the lock is transparent.
        if (N == 1) begin : g_single
            assign grant    = req_valid;
            assign ptr_next = ptr_reg;
        end else begin : g_multi
            assign grant    = (state_reg == ARB_LOCK) ? (req_valid & owner_oh)
                                                      : (pick_any ? pick_gnt : '0);
            assign ptr_next = {grant[N-2:0], grant[N-1]};
        end
    endgenerate

    assign req_ready = {N{load & ~rst}} & grant;
    assign accept    = |(req_valid & req_ready);
    assign sel_last  = |(grant & req_last);

    always_comb begin
        sel_data = '0;
        win_idx  = '0;
        for (int i = 0; i < N; i++) begin
            sel_data = sel_data | lane_data[i];
            if (grant[i]) begin
                win_idx = win_idx | SW'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_src_reg   <= '0;
            out_last_reg  <= 1'b0;
        end else if (accept) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= sel_data;
            out_src_reg   <= win_idx;
            out_last_reg  <= sel_last;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    // Lock is taken on a non-last beat and released only by the owner's last beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ARB_IDLE;
            ptr_reg   <= N'(1);
            owner_reg <= '0;
        end else if (accept) begin
            if (state_reg == ARB_IDLE && !sel_last) begin
                state_reg <= ARB_LOCK;
                owner_reg <= win_idx;
            end else if (state_reg == ARB_LOCK && sel_last) begin
                state_reg <= ARB_IDLE;
            end
            if (sel_last && !IS_FIXED) begin
                ptr_reg <= ptr_next;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_src   = out_src_reg;
    assign out_last  = out_last_reg;

endmodule
